// File: rtl/ifetch_queue.sv
// ifetch_queue: sequential instruction fetch into a DEPTH-entry {instr, pc} FIFO
// with credit-based request throttling and same-cycle branch-redirect flush.
// Optional build macro IFQ_STATS_EN adds saturating stat_fetched/stat_flushed counters.
module ifetch_queue #(
  parameter int unsigned      WIDTH    = 32,
  parameter int unsigned      DEPTH    = 4,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter logic [WIDTH-1:0] PC_INC   = WIDTH'(4)
) (
  input  logic                         clk,
  input  logic                         reset,
  output logic [WIDTH-1:0]             imem_addr,
  output logic                         imem_req,
  input  logic [WIDTH-1:0]             imem_rdata,
  input  logic                         redirect_valid,
  input  logic [WIDTH-1:0]             redirect_pc,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_instr,
  output logic [WIDTH-1:0]             out_pc,
`ifdef IFQ_STATS_EN
  output logic [15:0]                  stat_fetched,
  output logic [15:0]                  stat_flushed,
`endif
  output logic [$clog2(DEPTH+1)-1:0]   out_count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic             req_q, req_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [WIDTH-1:0] instr_mem_q [DEPTH];
  logic [WIDTH-1:0] instr_mem_d [DEPTH];
  logic [WIDTH-1:0] pc_mem_q    [DEPTH];
  logic [WIDTH-1:0] pc_mem_d    [DEPTH];

  logic [CNT_W:0]   outstanding_c;
  logic             push_c;
  logic             pop_c;

  // Fetch side: credit check, redirect bypass of the address, next sequential pc
  always_comb begin
    outstanding_c = {1'b0, count_q} + (CNT_W+1)'(req_q);
    imem_req      = !reset && (redirect_valid || (outstanding_c < (CNT_W+1)'(DEPTH)));
    imem_addr     = redirect_valid ? redirect_pc : fetch_pc_q;
    fetch_pc_d    = fetch_pc_q;
    if (imem_req) begin
      fetch_pc_d = imem_addr + PC_INC;
    end
    req_d = imem_req;
    pc_d  = imem_addr;
  end

  // Queue side: capture returning word, serve head, flush on redirect
  always_comb begin
    push_c      = req_q && !redirect_valid;
    out_valid   = (count_q != '0) && !redirect_valid;
    pop_c       = out_valid && out_ready;
    count_d     = count_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    instr_mem_d = instr_mem_q;
    pc_mem_d    = pc_mem_q;
    if (redirect_valid) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (push_c) begin
        instr_mem_d[wr_ptr_q] = imem_rdata;
        pc_mem_d[wr_ptr_q]    = pc_q;
        wr_ptr_d              = wr_ptr_q + PTR_W'(1);
      end
      if (pop_c) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
    end
    out_instr = instr_mem_q[rd_ptr_q];
    out_pc    = pc_mem_q[rd_ptr_q];
    out_count = count_q;
  end

  // Control state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      pc_q       <= RESET_PC;
      req_q      <= 1'b0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      pc_q       <= pc_d;
      req_q      <= req_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // Queue storage; contents are don't-care until written so no reset
  always_ff @(posedge clk) begin
    instr_mem_q <= instr_mem_d;
    pc_mem_q    <= pc_mem_d;
  end

  // Credit accounting must never allow a push into a full queue
  a_no_push_full: assert property (@(posedge clk) disable iff (reset)
    !(push_c && (count_q == CNT_W'(DEPTH))));

`ifdef IFQ_STATS_EN
  logic [15:0] stat_fetched_q, stat_fetched_d;
  logic [15:0] stat_flushed_q, stat_flushed_d;
  logic [16:0] flush_sum_c;

  // Saturating pop and flushed-word counters
  always_comb begin
    stat_fetched_d = stat_fetched_q;
    stat_flushed_d = stat_flushed_q;
    flush_sum_c    = 17'(stat_flushed_q) + 17'(outstanding_c);
    if (pop_c && (stat_fetched_q != 16'hFFFF)) begin
      stat_fetched_d = stat_fetched_q + 16'd1;
    end
    if (redirect_valid) begin
      stat_flushed_d = flush_sum_c[16] ? 16'hFFFF : flush_sum_c[15:0];
    end
    stat_fetched = stat_fetched_q;
    stat_flushed = stat_flushed_q;
  end

  // Statistics registers
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_fetched_q <= '0;
      stat_flushed_q <= '0;
    end else begin
      stat_fetched_q <= stat_fetched_d;
      stat_flushed_q <= stat_flushed_d;
    end
  end
`endif

endmodule
